// File: rtl/datapath_sequencer.sv
// Command sequencer for the 16-register byte datapath: LOAD/ALU/READ/CLR over valid/ready.
// Optional performance counters are enabled with `define DP_SEQ_PERF_EN.
`timescale 1ns/1ps
module datapath_sequencer #(
  parameter int NREG = 16
`ifdef DP_SEQ_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_wa,
  input  logic [3:0]  cmd_raa,
  input  logic [3:0]  cmd_rab,
  input  logic [3:0]  cmd_sel,
  input  logic [2:0]  cmd_alu,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [6:0]  res_data,
  output logic        res_flag,
  output logic        err,
  output logic [3:0]  Sel,
  output logic        Wen,
  output logic [3:0]  WA,
  output logic [3:0]  RAA,
  output logic [3:0]  RAB,
  output logic [2:0]  Op,
  output logic [7:0]  Ctrl,
  input  logic [6:0]  OutPort,
  input  logic        Flag
`ifdef DP_SEQ_PERF_EN
  , output logic [PERF_W-1:0] perf_cmds
  , output logic [PERF_W-1:0] perf_errs
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ALU, S_READ, S_RESP, S_CLR} state_t;

  state_t          state, next_state;
  logic            rdy_q;
  logic [3:0]      wa_q, raa_q, rab_q, sel_q;
  logic [2:0]      alu_q;
  logic [NREG-1:0] mask;
  logic            accept, a_ok, alu_ok;

  // rdy_q keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = rdy_q && (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign res_valid = (state == S_RESP);
  assign a_ok      = mask[raa_q];
  assign alu_ok    = mask[raa_q] && mask[rab_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rdy_q <= 1'b0;
      wa_q  <= '0;
      raa_q <= '0;
      rab_q <= '0;
      sel_q <= '0;
      alu_q <= '0;
    end else begin
      state <= next_state;
      rdy_q <= 1'b1;
      if (accept) begin
        wa_q  <= cmd_wa;
        raa_q <= cmd_raa;
        rab_q <= cmd_rab;
        sel_q <= cmd_sel;
        alu_q <= cmd_alu;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            2'b00:   next_state = S_LOAD;
            2'b01:   next_state = S_ALU;
            2'b10:   next_state = S_READ;
            default: next_state = S_CLR;
          endcase
        end
      end
      S_READ:  next_state = a_ok ? S_RESP : S_IDLE;
      S_RESP:  next_state = res_ready ? S_IDLE : S_RESP;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath pins decode from the state register and the latched command only
  always_comb begin
    Sel  = '0;
    Wen  = 1'b0;
    WA   = '0;
    RAA  = '0;
    RAB  = '0;
    Op   = '0;
    Ctrl = '0;
    err  = 1'b0;
    case (state)
      S_LOAD: begin
        Wen = 1'b1;
        WA  = wa_q;
        Sel = sel_q;
      end
      S_ALU: begin
        Wen  = alu_ok;
        WA   = wa_q;
        RAA  = raa_q;
        RAB  = rab_q;
        Op   = alu_q;
        Ctrl = 8'h01;
        err  = !alu_ok;
      end
      S_READ: begin
        Op  = 3'd4;
        RAA = raa_q;
        err = !a_ok;
      end
      default: ;
    endcase
  end

  // Mask check above uses the pre-write mask, so wa == raa/rab is safe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask     <= '0;
      res_data <= '0;
      res_flag <= 1'b0;
    end else begin
      case (state)
        S_LOAD: mask[wa_q] <= 1'b1;
        S_ALU: begin
          if (alu_ok) begin
            mask[wa_q] <= 1'b1;
            res_flag   <= Flag;
          end
        end
        S_READ: if (a_ok) res_data <= OutPort;
        S_CLR:  mask <= '0;
        default: ;
      endcase
    end
  end

`ifdef DP_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cmds <= '0;
      perf_errs <= '0;
    end else begin
      if (accept) perf_cmds <= perf_cmds + 1'b1;
      if (err)    perf_errs <= perf_errs + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed testbench for datapath_sequencer; OutPort/Flag are driven directly by the bench.
`timescale 1ns/1ps
module tb_datapath_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_wa, cmd_raa, cmd_rab, cmd_sel;
  logic [2:0] cmd_alu;
  logic       res_valid, res_ready;
  logic [6:0] res_data;
  logic       res_flag, err;
  logic [3:0] Sel, WA, RAA, RAB;
  logic       Wen;
  logic [2:0] Op;
  logic [7:0] Ctrl;
  logic [6:0] OutPort;
  logic       Flag;
`ifdef DP_SEQ_PERF_EN
  logic [15:0] perf_cmds, perf_errs;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int expCmds = 0;
  int expErrs = 0;

  always #5 clk = ~clk;

  datapath_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wa(cmd_wa), .cmd_raa(cmd_raa), .cmd_rab(cmd_rab),
    .cmd_sel(cmd_sel), .cmd_alu(cmd_alu),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flag(res_flag), .err(err),
    .Sel(Sel), .Wen(Wen), .WA(WA), .RAA(RAA), .RAB(RAB), .Op(Op), .Ctrl(Ctrl),
    .OutPort(OutPort), .Flag(Flag)
`ifdef DP_SEQ_PERF_EN
    , .perf_cmds(perf_cmds), .perf_errs(perf_errs)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one command at a negedge and returns at the negedge of its execute cycle
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] wa, input logic [3:0] raa,
                               input logic [3:0] rab, input logic [3:0] sel, input logic [2:0] alu);
    int waitCnt = 0;
    @(negedge clk);
    while (!cmd_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("cmdReadyBeforeIssue", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_wa = wa; cmd_raa = raa; cmd_rab = rab; cmd_sel = sel; cmd_alu = alu;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    expCmds++;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_wa = '0; cmd_raa = '0; cmd_rab = '0;
    cmd_sel = '0; cmd_alu = '0; res_ready = 1'b0; OutPort = '0; Flag = 1'b0;

    // Reset state
    #2;
    checkOutput("rstCmdReady", 32'(cmd_ready), 32'd0);
    checkOutput("rstResValid", 32'(res_valid), 32'd0);
    checkOutput("rstWen", 32'(Wen), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    checkOutput("rstResData", 32'(res_data), 32'd0);
    checkOutput("rstResFlag", 32'(res_flag), 32'd0);
    @(negedge clk);
    checkOutput("rstCmdReadyAfterEdge", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("cmdReadyAfterRelease", 32'(cmd_ready), 32'd1);

    // READ of an unwritten register right after reset
    applyStimulus(2'b10, 4'd0, 4'd7, 4'd0, 4'd0, 3'd0);
    checkOutput("rd7Err", 32'(err), 32'd1);
    checkOutput("rd7Wen", 32'(Wen), 32'd0);
    expErrs++;
    @(negedge clk);
    checkOutput("rd7ErrOneCycle", 32'(err), 32'd0);
    checkOutput("rd7NoResValid", 32'(res_valid), 32'd0);
    checkOutput("rd7CmdReadyBack", 32'(cmd_ready), 32'd1);

    // LOAD r3 then READ r3
    applyStimulus(2'b00, 4'd3, 4'd0, 4'd0, 4'd2, 3'd0);
    checkOutput("ld3Wen", 32'(Wen), 32'd1);
    checkOutput("ld3WA", 32'(WA), 32'd3);
    checkOutput("ld3Sel", 32'(Sel), 32'd2);
    checkOutput("ld3Ctrl", 32'(Ctrl), 32'h00);
    checkOutput("ld3CmdReady", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput("ld3WenOneCycle", 32'(Wen), 32'd0);
    OutPort = 7'h5A;
    applyStimulus(2'b10, 4'd0, 4'd3, 4'd0, 4'd0, 3'd0);
    checkOutput("rd3Op", 32'(Op), 32'd4);
    checkOutput("rd3RAA", 32'(RAA), 32'd3);
    checkOutput("rd3Wen", 32'(Wen), 32'd0);
    checkOutput("rd3Err", 32'(err), 32'd0);
    @(negedge clk);
    checkOutput("rd3ResValid", 32'(res_valid), 32'd1);
    checkOutput("rd3ResData", 32'(res_data), 32'h5A);
    checkOutput("rd3CmdReady", 32'(cmd_ready), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("rd3ResDone", 32'(res_valid), 32'd0);
    checkOutput("rd3IdleReady", 32'(cmd_ready), 32'd1);
    res_ready = 1'b0;

    // LOAD r1, LOAD r2, ALU r5 = op1(r1, r2) with Flag=1
    applyStimulus(2'b00, 4'd1, 4'd0, 4'd0, 4'd0, 3'd0);
    applyStimulus(2'b00, 4'd2, 4'd0, 4'd0, 4'd1, 3'd0);
    Flag = 1'b1;
    applyStimulus(2'b01, 4'd5, 4'd1, 4'd2, 4'd0, 3'd1);
    checkOutput("aluWen", 32'(Wen), 32'd1);
    checkOutput("aluWA", 32'(WA), 32'd5);
    checkOutput("aluRAA", 32'(RAA), 32'd1);
    checkOutput("aluRAB", 32'(RAB), 32'd2);
    checkOutput("aluOp", 32'(Op), 32'd1);
    checkOutput("aluCtrl", 32'(Ctrl), 32'h01);
    checkOutput("aluErr", 32'(err), 32'd0);
    @(negedge clk);
    checkOutput("aluResFlag", 32'(res_flag), 32'd1);
    Flag = 1'b0;

    // READ r5 (mask set by ALU) with res_ready stalled for 10 cycles
    OutPort = 7'h33;
    applyStimulus(2'b10, 4'd0, 4'd5, 4'd0, 4'd0, 3'd0);
    checkOutput("rd5Err", 32'(err), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stallResValid", 32'(res_valid), 32'd1);
      checkOutput("stallResData", 32'(res_data), 32'h33);
      checkOutput("stallCmdReady", 32'(cmd_ready), 32'd0);
      OutPort = 7'(i);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("stallReleased", 32'(res_valid), 32'd0);
    checkOutput("stallIdleReady", 32'(cmd_ready), 32'd1);
    res_ready = 1'b0;

    // LOAD r4, ALU with wa == raa == rab and Flag=0
    applyStimulus(2'b00, 4'd4, 4'd0, 4'd0, 4'd3, 3'd0);
    applyStimulus(2'b01, 4'd4, 4'd4, 4'd4, 4'd0, 3'd2);
    checkOutput("aluSelfWen", 32'(Wen), 32'd1);
    checkOutput("aluSelfOp", 32'(Op), 32'd2);
    @(negedge clk);
    checkOutput("aluSelfResFlag", 32'(res_flag), 32'd0);

    // CLR then ALU on r4 must error and leave res_flag alone
    applyStimulus(2'b11, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
    checkOutput("clrWen", 32'(Wen), 32'd0);
    checkOutput("clrErr", 32'(err), 32'd0);
    Flag = 1'b1;
    applyStimulus(2'b01, 4'd6, 4'd4, 4'd4, 4'd0, 3'd3);
    checkOutput("aluClrErr", 32'(err), 32'd1);
    checkOutput("aluClrWen", 32'(Wen), 32'd0);
    expErrs++;
    @(negedge clk);
    checkOutput("aluClrErrOneCycle", 32'(err), 32'd0);
    checkOutput("aluClrResFlag", 32'(res_flag), 32'd0);
    Flag = 1'b0;
    applyStimulus(2'b10, 4'd0, 4'd5, 4'd0, 4'd0, 3'd0);
    checkOutput("rd5AfterClrErr", 32'(err), 32'd1);
    expErrs++;

`ifdef DP_SEQ_PERF_EN
    @(negedge clk);
    checkOutput("perfCmds", 32'(perf_cmds), 32'(expCmds));
    checkOutput("perfErrs", 32'(perf_errs), 32'(expErrs));
`endif

    // Reset while a result is pending
    applyStimulus(2'b00, 4'd4, 4'd0, 4'd0, 4'd3, 3'd0);
    OutPort = 7'h22;
    applyStimulus(2'b10, 4'd0, 4'd4, 4'd0, 4'd0, 3'd0);
    @(negedge clk);
    checkOutput("preRstResValid", 32'(res_valid), 32'd1);
    checkOutput("preRstResData", 32'(res_data), 32'h22);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstResValid", 32'(res_valid), 32'd0);
    checkOutput("midRstCmdReady", 32'(cmd_ready), 32'd0);
    checkOutput("midRstResData", 32'(res_data), 32'd0);
    checkOutput("midRstWen", 32'(Wen), 32'd0);
    expCmds = 0;
    expErrs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b10, 4'd0, 4'd4, 4'd0, 4'd0, 3'd0);
    checkOutput("rd4AfterRstErr", 32'(err), 32'd1);
    expErrs++;
    @(negedge clk);
    checkOutput("rd4AfterRstNoRes", 32'(res_valid), 32'd0);
`ifdef DP_SEQ_PERF_EN
    checkOutput("perfCmdsAfterRst", 32'(perf_cmds), 32'(expCmds));
    checkOutput("perfErrsAfterRst", 32'(perf_errs), 32'(expErrs));
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Command-driven controller that sequences the 16-register byte datapath (InPort/Sel byte load, ALU ops, OutPort read). Accepts one command at a time over a valid/ready handshake and drives the datapath control pins for the required cycles. Returns read results over a valid/ready response channel. Tracks which registers hold defined data and flags reads of unwritten registers as errors.

Parameters:
NREG, 16, number of datapath registers; fixed at 16 to match 4-bit addresses.
PERF_W, 16, width of the performance counters when the optional feature is enabled.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer accepts a command
cmd_op  input  2  00 LOAD, 01 ALU, 10 READ, 11 CLR
cmd_wa  input  4  destination register
cmd_raa  input  4  source A register
cmd_rab  input  4  source B register
cmd_sel  input  4  InPort byte index for LOAD
cmd_alu  input  3  ALU opcode for ALU
res_valid  output  1  read result available
res_ready  input  1  consumer takes result
res_data  output  7  captured OutPort value
res_flag  output  1  Flag captured by last ALU command
err  output  1  one-cycle pulse: source register not yet written
Sel  output  4  datapath byte select
Wen  output  1  datapath write enable
WA  output  4  datapath write address
RAA  output  4  datapath read address A
RAB  output  4  datapath read address B
Op  output  3  datapath ALU opcode
Ctrl  output  8  datapath control; bit0 = write source (0 InPort byte, 1 ALU result), bits 7:1 = 0
OutPort  input  7  datapath output
Flag  input  1  datapath ALU flag

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all datapath outputs 0.
  - cmd_ready=0 while rst_n low; 1 from the first clock edge after deassertion.
  - res_valid=0, res_data=0, res_flag=0, err=0.
  - Written-mask (16 bits) cleared.
- Reset mid-operation aborts the command with no further Wen; the result is discarded.
- Datapath outputs are registered from the state and the latched command. In IDLE: Wen=0, Op=0, Ctrl=0; address/select outputs hold 0.
- IDLE: cmd_ready=1. Handshake on cmd_valid&&cmd_ready latches all cmd_* fields; next state by cmd_op. cmd_ready=0 in every other state.
- LOAD (1 cycle):
  - Wen=1, WA=wa, Sel=sel, Ctrl=0x00.
  - Set mask[wa]. Next state IDLE.
- ALU (1 cycle):
  - If mask[raa] and mask[rab]: Wen=1, WA=wa, RAA=raa, RAB=rab, Op=alu, Ctrl=0x01; set mask[wa]; res_flag<=Flag at the end of the cycle.
  - Otherwise: Wen=0, err pulses 1 cycle, mask and res_flag unchanged.
  - Next state IDLE.
- READ (1 cycle):
  - Op=4 (pass A), RAA=raa, Wen=0.
  - If mask[raa]: res_data<=OutPort at the end of the cycle; next state RESP.
  - Otherwise: err pulse; next state IDLE.
- RESP:
  - res_valid=1; res_data stable until res_valid&&res_ready; then next state IDLE and res_valid=0.
  - res_ready high on entry completes in 1 cycle.
  - res_ready=0 indefinitely stalls the sequencer with no timeout.
- CLR (1 cycle): mask<=0, Wen=0; next state IDLE.
- Timing:
  - Per-command latency: 2 cycles for LOAD/ALU/CLR (accept + execute); READ result is valid 2 cycles after accept.
  - Maximum throughput: 1 command per 2 cycles.
- ALU with wa equal to raa or rab is legal; the mask check uses pre-write mask state.
- err never coincides with Wen=1.

Optional Feature:
DP_SEQ_PERF_EN
- Defined:
  - Adds outputs perf_cmds[PERF_W-1:0] (increments on each accepted command) and perf_errs[PERF_W-1:0] (increments on each err pulse).
  - Both cleared by reset; both wrap from all-ones to 0; not cleared by CLR.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then LOAD wa=3 sel=2 with InPort byte2=0x5A -> one cycle Wen=1 WA=3 Sel=2 Ctrl=0x00; then READ raa=3 -> Op=4 RAA=3; res_valid with res_data=0x5A.
- READ raa=7 right after reset -> err pulse of exactly 1 cycle, no res_valid, cmd_ready back high 2 cycles after accept.
- LOAD r1, LOAD r2, ALU alu=1 wa=5 raa=1 rab=2 with Flag=1 in the execute cycle -> Wen=1 WA=5 Op=1 Ctrl=0x01; res_flag=1; mask[5] set.
- READ with res_ready held 0 for 10 cycles -> res_valid and res_data stable, cmd_ready=0 throughout; res_ready=1 -> IDLE next cycle.
- CLR after LOAD r4, then ALU raa=4 -> err pulse, Wen stays 0, res_flag unchanged.
- rst_n low during RESP -> res_valid=0 immediately, mask cleared, outputs 0; under DP_SEQ_PERF_EN, 2^16 accepted commands -> perf_cmds wraps to 0.
